mmio_timer_core: RTL and testbench



---
 rtl/timer_pkg.sv | 20 ++
 rtl/timer_prescaler.sv | 29 ++
 rtl/mmio_timer_core.sv | 109 ++++++++++
 tb/tb_mmio_timer_core.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the MMIO timer/compare slot.
package timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_PRESCALE = 5'd1;
    localparam logic [4:0] REG_COMPARE  = 5'd2;
    localparam logic [4:0] REG_COUNT    = 5'd3;
    localparam logic [4:0] REG_STATUS   = 5'd4;

    localparam int CTRL_W            = 4;
    localparam int CTRL_EN           = 0;
    localparam int CTRL_PERIODIC     = 1;
    localparam int CTRL_IRQ_EN_MATCH = 2;
    localparam int CTRL_IRQ_EN_OVF   = 3;

    localparam int STAT_W     = 2;
    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: emits one tick every period+1 enabled clocks; restarts on clr or when disabled.
module timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] pcnt;

    // tick depends only on the current count, so a clear still lets this cycle's tick through.
    assign tick = en && (pcnt == period);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clr || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO timer slot: 32-bit up-counter with prescaler, compare match, sticky flags and level irq.
module mmio_timer_core
    import timer_pkg::*;
#(
    parameter int          PRE_W         = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl;
    logic [PRE_W-1:0]  prescale;
    logic [31:0]       compare;
    logic [31:0]       count;
    logic [STAT_W-1:0] status;
    logic [STAT_W-1:0] set_flags;

    logic wr_en, wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_stat;
    logic tick, pre_clr, hit, wrap, oneshot_stop;
    logic unused_read;

    assign unused_read = read;

    assign wr_en   = cs && write;
    assign wr_ctrl = wr_en && (addr == REG_CTRL);
    assign wr_pre  = wr_en && (addr == REG_PRESCALE);
    assign wr_cmp  = wr_en && (addr == REG_COMPARE);
    assign wr_cnt  = wr_en && (addr == REG_COUNT);
    assign wr_stat = wr_en && (addr == REG_STATUS);

    assign pre_clr = wr_pre || (wr_ctrl && wr_data[CTRL_EN]);

    timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl[CTRL_EN]),
        .clr    (pre_clr),
        .period (prescale),
        .tick   (tick)
    );

    // A software COUNT load pre-empts the tick entirely, including the compare.
    assign hit          = tick && !wr_cnt && (count == compare);
    assign wrap         = tick && !wr_cnt && !hit && (count == 32'hFFFF_FFFF);
    assign oneshot_stop = hit && !ctrl[CTRL_PERIODIC];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        set_flags             = '0;
        set_flags[STAT_MATCH] = hit;
        set_flags[STAT_OVF]   = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= RESET_COMPARE;
            count    <= '0;
            status   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wr_data[CTRL_W-1:0];
            end else if (oneshot_stop) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_pre) prescale <= wr_data[PRE_W-1:0];
            if (wr_cmp) compare  <= wr_data;

            if (wr_cnt) begin
                count <= wr_data;
            end else if (hit) begin
                if (ctrl[CTRL_PERIODIC]) count <= '0;
            end else if (wrap) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
            end

            // Set beats write-one-to-clear when both land on the same edge.
            status <= (wr_stat ? (status & ~wr_data[STAT_W-1:0]) : status) | set_flags;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CTRL:     rd_data = 32'(ctrl);
            REG_PRESCALE: rd_data = 32'(prescale);
            REG_COMPARE:  rd_data = compare;
            REG_COUNT:    rd_data = count;
            REG_STATUS:   rd_data = 32'(status);
            default:      rd_data = '0;
        endcase
    end

    assign irq = (status[STAT_MATCH] && ctrl[CTRL_IRQ_EN_MATCH]) ||
                 (status[STAT_OVF]   && ctrl[CTRL_IRQ_EN_OVF]);

endmodule

// File: tb/tb_mmio_timer_core.sv
// Self-checking bench for mmio_timer_core: per-cycle model comparison plus directed literal checks.
module tb_mmio_timer_core;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        cs      = 1'b0;
    logic        read    = 1'b0;
    logic        write   = 1'b0;
    logic [4:0]  addr    = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_timer_core #(
        .PRE_W         (16),
        .RESET_COMPARE (32'hFFFF_FFFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq)
    );

    // Behavioural model: register values plus the number of enabled cycles since the prescaler restarted.
    logic [3:0]  m_ctrl  = '0;
    int unsigned m_pre   = 0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic [31:0] m_cnt   = '0;
    logic        m_match = 1'b0;
    logic        m_ovf   = 1'b0;
    int unsigned m_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd0:    return {28'b0, m_ctrl};
            5'd1:    return m_pre;
            5'd2:    return m_cmp;
            5'd3:    return m_cnt;
            5'd4:    return {30'b0, m_ovf, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return (m_match && m_ctrl[2]) || (m_ovf && m_ctrl[3]);
    endfunction

    task automatic model_step();
        logic        we, tk, hit_s, ovf_s;
        logic [3:0]  n_ctrl;
        int unsigned n_pre;
        logic [31:0] n_cmp, n_cnt;
        logic        n_match, n_ovf;
        we      = cs && write;
        tk      = m_ctrl[0] && ((m_phase % (m_pre + 1)) == m_pre);
        hit_s   = 1'b0;
        ovf_s   = 1'b0;
        n_ctrl  = m_ctrl;
        n_pre   = m_pre;
        n_cmp   = m_cmp;
        n_cnt   = m_cnt;
        if (we && addr == 5'd3) begin
            n_cnt = wr_data;
        end else if (tk) begin
            if (m_cnt == m_cmp) begin
                hit_s = 1'b1;
                if (m_ctrl[1]) n_cnt = 32'd0;
                else           n_ctrl[0] = 1'b0;
            end else if (m_cnt == 32'hFFFF_FFFF) begin
                n_cnt = 32'd0;
                ovf_s = 1'b1;
            end else begin
                n_cnt = m_cnt + 32'd1;
            end
        end
        if (we && addr == 5'd0) n_ctrl = wr_data[3:0];
        if (we && addr == 5'd1) n_pre  = {16'b0, wr_data[15:0]};
        if (we && addr == 5'd2) n_cmp  = wr_data;
        n_match = m_match;
        n_ovf   = m_ovf;
        if (we && addr == 5'd4) begin
            if (wr_data[0]) n_match = 1'b0;
            if (wr_data[1]) n_ovf   = 1'b0;
        end
        n_match = n_match | hit_s;
        n_ovf   = n_ovf | ovf_s;
        if (!m_ctrl[0] || (we && addr == 5'd1) || (we && addr == 5'd0 && wr_data[0]))
            m_phase = 0;
        else
            m_phase = m_phase + 1;
        m_ctrl  = n_ctrl;
        m_pre   = n_pre;
        m_cmp   = n_cmp;
        m_cnt   = n_cnt;
        m_match = n_match;
        m_ovf   = n_ovf;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl  = '0;
            m_pre   = 0;
            m_cmp   = 32'hFFFF_FFFF;
            m_cnt   = '0;
            m_match = 1'b0;
            m_ovf   = 1'b0;
            m_phase = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("cyc_rd", rd_data, model_rd(addr));
        check("cyc_irq", {31'b0, irq}, {31'b0, model_irq()});
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        check(name, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // Reset values
        check_rd("rst_ctrl", 5'd0, 32'h0);
        check_rd("rst_pre", 5'd1, 32'h0);
        check_rd("rst_cmp", 5'd2, 32'hFFFF_FFFF);
        cyc(1);
        check_rd("rst_cnt", 5'd3, 32'h0);
        check_rd("rst_stat", 5'd4, 32'h0);
        check_rd("rst_off5", 5'd5, 32'h0);
        check_irq("rst_irq", 1'b0);

        // Periodic match, PRESCALE=0, COMPARE=3; CTRL lands at E0
        bus_wr(5'd2, 32'd3);
        bus_wr(5'd0, 32'h7);
        cyc(); check_rd("per_cnt_e1", 5'd3, 32'd1);
        cyc(); check_rd("per_cnt_e2", 5'd3, 32'd2);
        cyc(); check_rd("per_cnt_e3", 5'd3, 32'd3);
        cyc();
        check_rd("per_stat_e4", 5'd4, 32'd1);
        check_rd("per_cnt_e4", 5'd3, 32'd0);
        check_irq("per_irq_e4", 1'b1);
        bus_wr(5'd4, 32'd1);
        check_rd("per_clr_e5", 5'd4, 32'd0);
        check_rd("per_cnt_e5", 5'd3, 32'd1);
        check_irq("per_irq_e5", 1'b0);
        cyc(2);
        check_rd("per_cnt_e7", 5'd3, 32'd3);
        // W1C lands on the same edge as the second match (E8)
        bus_wr(5'd4, 32'd1);
        check_rd("w1c_coll_stat", 5'd4, 32'd1);
        check_rd("per_cnt_e8", 5'd3, 32'd0);
        check_irq("w1c_coll_irq", 1'b1);
        bus_wr(5'd4, 32'd1);
        check_rd("w1c_after_stat", 5'd4, 32'd0);
        check_irq("w1c_after_irq", 1'b0);
        bus_wr(5'd0, 32'h0);

        // One-shot, PRESCALE=2, COMPARE=2
        bus_wr(5'd3, 32'd0);
        bus_wr(5'd1, 32'd2);
        bus_wr(5'd2, 32'd2);
        bus_wr(5'd0, 32'h5);
        cyc(8);
        check_rd("os_stat_e8", 5'd4, 32'd0);
        check_rd("os_cnt_e8", 5'd3, 32'd2);
        cyc();
        check_rd("os_stat_e9", 5'd4, 32'd1);
        check_irq("os_irq_e9", 1'b1);
        check_rd("os_ctrl_e9", 5'd0, 32'h4);
        cyc(20);
        check_rd("os_cnt_hold", 5'd3, 32'd2);
        check_rd("os_ctrl_hold", 5'd0, 32'h4);

        // Overflow
        bus_wr(5'd4, 32'd3);
        bus_wr(5'd1, 32'd0);
        bus_wr(5'd3, 32'hFFFF_FFFE);
        bus_wr(5'd2, 32'd5);
        bus_wr(5'd0, 32'h9);
        cyc(); check_rd("ovf_cnt_e1", 5'd3, 32'hFFFF_FFFF);
        cyc();
        check_rd("ovf_cnt_e2", 5'd3, 32'd0);
        check_rd("ovf_stat_e2", 5'd4, 32'd2);
        check_irq("ovf_irq_e2", 1'b1);
        bus_wr(5'd4, 32'd2);
        check_rd("ovf_clr_stat", 5'd4, 32'd0);
        check_irq("ovf_clr_irq", 1'b0);
        bus_wr(5'd0, 32'h0);

        // Bus isolation
        cs = 1'b0; write = 1'b1; addr = 5'd0; wr_data = 32'd1;
        cyc();
        write = 1'b0; wr_data = '0;
        check_rd("iso_cs_ctrl", 5'd0, 32'h0);
        bus_wr(5'd7, 32'hFFFF_FFFF);
        check_rd("iso_off7_ctrl", 5'd0, 32'h0);
        check_rd("iso_off7_cmp", 5'd2, 32'd5);
        check_rd("iso_off7_cnt", 5'd3, 32'd2);
        cyc();
        check_rd("iso_off7_pre", 5'd1, 32'd0);
        check_rd("iso_off7_stat", 5'd4, 32'd0);
        check_rd("iso_rd9", 5'd9, 32'd0);

        // Asynchronous reset mid-count
        bus_wr(5'd3, 32'd0);
        bus_wr(5'd2, 32'd100);
        bus_wr(5'd0, 32'h1);
        cyc(3);
        check_rd("arst_pre_cnt", 5'd3, 32'd3);
        #1 reset = 1'b1;
        check_rd("arst_cnt", 5'd3, 32'd0);
        check_rd("arst_ctrl", 5'd0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(5);
        check_rd("arst_cnt_idle", 5'd3, 32'd0);
        check_rd("arst_cmp", 5'd2, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
